// File: rtl/aer_pkg.sv
// aer_pkg: shared defaults and event layout for the spike AER encoder
package aer_pkg;
    localparam int N_NEURONS_DEF  = 4;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int TS_W_DEF       = 8;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W_DEF = id_w(N_NEURONS_DEF);

    // Event word: neuron id in the MSBs, capture timestamp in the LSBs
    typedef struct packed {
        logic [ID_W_DEF-1:0] id;
        logic [TS_W_DEF-1:0] ts;
    } aer_event_t;
endpackage

// File: rtl/aer_fifo.sv
// aer_fifo: synchronous first-word-fall-through event queue
module aer_fifo #(
    parameter int W = 10,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wr_data,
    input  logic          pop,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;

    assign count   = wr_ptr - rd_ptr;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the empty flag masks stale entries
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: timestamps neuron spikes and queues them as AER events
module spike_aer_encoder import aer_pkg::*; #(
    parameter int N_NEURONS  = N_NEURONS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int TS_W       = TS_W_DEF,
    localparam int ID_W      = id_w(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_NEURONS-1:0] spike_in,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [ID_W+TS_W-1:0] ev_data,
    output logic [7:0]           drop_cnt
);
    localparam int EV_W = ID_W + TS_W;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;

    logic [TS_W-1:0]      ts;
    logic [N_NEURONS-1:0] pending;
    logic [TS_W-1:0]      ts_cap [N_NEURONS];
    logic                 any_pend, push, full, empty;
    logic [ID_W-1:0]      gnt;
    logic [N_NEURONS-1:0] push_mask, drop_mask;
    logic [8:0]           n_drop, drop_sum;
    logic [EV_W-1:0]      head;
    logic [CW-1:0]        fifo_count;

    // Fixed-priority arbiter: lowest pending index wins the single push slot
    always_comb begin
        any_pend = 1'b0;
        gnt = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                any_pend = 1'b1;
                gnt = ID_W'(i);
            end
        end
    end

    assign push      = any_pend && !full;
    assign push_mask = push ? (N_NEURONS'(1) << gnt) : '0;
    assign drop_mask = spike_in & pending & ~push_mask;

    // Count spikes that hit a still-occupied pending slot this cycle
    always_comb begin
        n_drop = '0;
        for (int i = 0; i < N_NEURONS; i++) n_drop = n_drop + 9'(drop_mask[i]);
    end

    assign drop_sum = {1'b0, drop_cnt} + n_drop;

    // Timestamp counter, per-neuron capture slots and saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts       <= '0;
            pending  <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < N_NEURONS; i++) ts_cap[i] <= '0;
        end else begin
            ts       <= ts + TS_W'(1);
            drop_cnt <= drop_sum[8] ? 8'hff : drop_sum[7:0];
            for (int i = 0; i < N_NEURONS; i++) begin
                if (spike_in[i] && (!pending[i] || push_mask[i])) begin
                    pending[i] <= 1'b1;
                    ts_cap[i]  <= ts;
                end else if (push_mask[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    aer_fifo #(.W(EV_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data ({gnt, ts_cap[gnt]}),
        .pop     (ev_ready),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    assign ev_valid = !empty;
    assign ev_data  = (fifo_count != '0) ? head : '0;
endmodule
